// File: rtl/led_sense_seq_pkg.sv
// led_sense_pkg: shared types and constants for the LED light-sense sequencer.
//   - state_t        : measurement state machine encoding (also reported in STAT)
//   - OFF_*          : register word offsets (iomem_addr[3:2])
//   - CTRL_* / STAT_*: bit positions inside the CTRL write / STAT read word
//   - DEF_*          : default parameter values
//   - merge_wstrb    : byte-lane merge of a bus write into an existing word
package led_sense_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHARGE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_CHARGE  = 2'd1;
    localparam logic [1:0] OFF_TIMEOUT = 2'd2;
    localparam logic [1:0] OFF_RESULT  = 2'd3;

    localparam int CTRL_START = 32'sd0;
    localparam int CTRL_CONT  = 32'sd1;
    localparam int CTRL_ABORT = 32'sd2;

    localparam int STAT_BUSY      = 32'sd0;
    localparam int STAT_DONE      = 32'sd1;
    localparam int STAT_TIMEOUT   = 32'sd2;
    localparam int STAT_CONT      = 32'sd3;
    localparam int STAT_STATE_LSB = 32'sd4;

    localparam logic [7:0]  DEF_BASE_ADDR = 8'h09;
    localparam int          DEF_CNT_WIDTH = 32'sd24;
    localparam int unsigned DEF_CHARGE    = 32'd1200;
    localparam int unsigned DEF_TIMEOUT   = 32'h00FF_FFFF;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] merge_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/led_sense_seq_if.sv
// led_sense_seq_if: PicoSoC iomem bus bundle.
//   master drives valid/wstrb/addr/wdata, slave returns ready/rdata.
interface led_sense_seq_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/led_sense_seq_bit_sync2.sv
// bit_sync2: two-flop synchroniser for a single bit.
//   clock, resetn (sync, active-low), d (async input), q (synchronised output).
// Resets to 1 so that a freshly reset block never sees a "discharged" pin.
module bit_sync2 (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Two-stage capture of the pad input.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/led_sense_seq.sv
// led_sense_seq: charge / measure sequencer for an LED used as a light sensor.
//   clock, resetn : system clock, synchronous active-low reset
//   bus           : iomem slave, decoded on iomem_addr[31:24] == BASE_ADDR
//                   0 CTRL/STAT, 1 CHARGE, 2 TIMEOUT, 3 RESULT (read clears flags)
//   pin_oe/pin_do : pad drive (high during CHARGE only)
//   pin_di        : pad input, synchronised internally (2 cycles counted in result)
//   done_irq      : one-cycle pulse in the DONE state
module led_sense_seq
    import led_sense_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR       = DEF_BASE_ADDR,
    parameter int          CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int unsigned CHARGE_DEFAULT  = DEF_CHARGE,
    parameter int unsigned TIMEOUT_DEFAULT = DEF_TIMEOUT
) (
    input  logic          clock,
    input  logic          resetn,
    led_sense_seq_if.slave bus,
    output logic          pin_oe,
    output logic          pin_do,
    input  logic          pin_di,
    output logic          done_irq
);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_r, state_next_s;
    logic [CNT_WIDTH-1:0] cnt_r, cnt_next_s;
    logic [CNT_WIDTH-1:0] result_r, result_next_s;
    logic [CNT_WIDTH-1:0] charge_r, timeout_r;
    logic [CNT_WIDTH-1:0] charge_eff_s, timeout_eff_s;
    logic                 done_r, timeout_flag_r, cont_r;
    logic                 ready_r, pin_oe_r, pin_do_r, done_irq_r;
    logic [31:0]          rdata_r, rdata_next_s;
    logic [31:0]          stat_s, charge_ext_s, timeout_ext_s, result_ext_s;
    logic [31:0]          charge_wr_s, timeout_wr_s;
    logic                 di_s;
    logic                 sel_s, wr_s, rd_s, ctrl_wr_s;
    logic                 start_s, abort_s, rd_result_s;
    logic                 done_set_s, timeout_set_s, flags_clr_s;
    logic [1:0]           off_s;
    logic                 unused_addr_s;

    bit_sync2 u_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (pin_di),
        .q      (di_s)
    );

    assign unused_addr_s = ^{bus.iomem_addr[23:4], bus.iomem_addr[1:0]};

    // Bus decode: a new request is accepted only while no acknowledge is pending.
    always_comb begin
        off_s       = bus.iomem_addr[3:2];
        sel_s       = bus.iomem_valid && (bus.iomem_addr[31:24] == BASE_ADDR) && !ready_r;
        wr_s        = sel_s && (bus.iomem_wstrb != 4'b0000);
        rd_s        = sel_s && (bus.iomem_wstrb == 4'b0000);
        ctrl_wr_s   = wr_s && (off_s == OFF_CTRL) && bus.iomem_wstrb[0];
        start_s     = ctrl_wr_s && bus.iomem_wdata[CTRL_START];
        abort_s     = ctrl_wr_s && bus.iomem_wdata[CTRL_ABORT];
        rd_result_s = rd_s && (off_s == OFF_RESULT);
    end

    // Register views widened to the bus, zero-value clamping, and read mux.
    always_comb begin
        charge_ext_s                   = 32'd0;
        timeout_ext_s                  = 32'd0;
        result_ext_s                   = 32'd0;
        charge_ext_s[CNT_WIDTH-1:0]    = charge_r;
        timeout_ext_s[CNT_WIDTH-1:0]   = timeout_r;
        result_ext_s[CNT_WIDTH-1:0]    = result_r;
        charge_wr_s  = merge_wstrb(charge_ext_s, bus.iomem_wdata, bus.iomem_wstrb);
        timeout_wr_s = merge_wstrb(timeout_ext_s, bus.iomem_wdata, bus.iomem_wstrb);
        charge_eff_s  = (charge_r == CNT_ZERO) ? CNT_ONE : charge_r;
        timeout_eff_s = (timeout_r == CNT_ZERO) ? CNT_ONE : timeout_r;
        stat_s                              = 32'd0;
        stat_s[STAT_BUSY]                   = (state_r != IDLE);
        stat_s[STAT_DONE]                   = done_r;
        stat_s[STAT_TIMEOUT]                = timeout_flag_r;
        stat_s[STAT_CONT]                   = cont_r;
        stat_s[STAT_STATE_LSB +: 3]         = {1'b0, state_r};
        case (off_s)
            OFF_CTRL:    rdata_next_s = stat_s;
            OFF_CHARGE:  rdata_next_s = charge_ext_s;
            OFF_TIMEOUT: rdata_next_s = timeout_ext_s;
            OFF_RESULT:  rdata_next_s = result_ext_s;
            default:     rdata_next_s = 32'd0;
        endcase
    end

    // Next-state logic. Bounds use >= so a bound lowered mid-phase still ends it.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        result_next_s = result_r;
        done_set_s    = 1'b0;
        timeout_set_s = 1'b0;
        flags_clr_s   = 1'b0;
        if (abort_s) begin
            state_next_s = IDLE;
            cnt_next_s   = CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_next_s = CHARGE;
                        cnt_next_s   = CNT_ZERO;
                        flags_clr_s  = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                CHARGE: begin
                    if (cnt_r >= charge_eff_s - CNT_ONE) begin
                        state_next_s = MEASURE;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (!di_s) begin
                        state_next_s  = DONE;
                        result_next_s = cnt_r;
                    end else if (cnt_r >= timeout_eff_s - CNT_ONE) begin
                        state_next_s  = DONE;
                        result_next_s = timeout_eff_s;
                        timeout_set_s = 1'b1;
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    done_set_s   = 1'b1;
                    cnt_next_s   = CNT_ZERO;
                    if (cont_r) begin
                        state_next_s = CHARGE;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter, result and registered pad / interrupt outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            result_r   <= CNT_ZERO;
            pin_oe_r   <= 1'b0;
            pin_do_r   <= 1'b0;
            done_irq_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            result_r   <= result_next_s;
            pin_oe_r   <= (state_next_s == CHARGE);
            pin_do_r   <= (state_next_s == CHARGE);
            done_irq_r <= (state_next_s == DONE);
        end
    end

    // Status flags: a set in the DONE cycle beats a same-cycle RESULT read.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            done_r         <= 1'b0;
            timeout_flag_r <= 1'b0;
        end else begin
            if (flags_clr_s) begin
                done_r <= 1'b0;
            end else if (done_set_s) begin
                done_r <= 1'b1;
            end else if (rd_result_s) begin
                done_r <= 1'b0;
            end
            if (flags_clr_s) begin
                timeout_flag_r <= 1'b0;
            end else if (timeout_set_s) begin
                timeout_flag_r <= 1'b1;
            end else if (rd_result_s) begin
                timeout_flag_r <= 1'b0;
            end
        end
    end

    // Bus acknowledge, read data capture and configuration register writes.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            ready_r   <= 1'b0;
            rdata_r   <= 32'd0;
            cont_r    <= 1'b0;
            charge_r  <= CNT_WIDTH'(CHARGE_DEFAULT);
            timeout_r <= CNT_WIDTH'(TIMEOUT_DEFAULT);
        end else begin
            ready_r <= sel_s;
            rdata_r <= sel_s ? rdata_next_s : 32'd0;
            if (ctrl_wr_s) begin
                cont_r <= bus.iomem_wdata[CTRL_CONT];
            end
            if (wr_s && (off_s == OFF_CHARGE)) begin
                charge_r <= charge_wr_s[CNT_WIDTH-1:0];
            end
            if (wr_s && (off_s == OFF_TIMEOUT)) begin
                timeout_r <= timeout_wr_s[CNT_WIDTH-1:0];
            end
        end
    end

    assign bus.iomem_ready = ready_r;
    assign bus.iomem_rdata = rdata_r;
    assign pin_oe          = pin_oe_r;
    assign pin_do          = pin_do_r;
    assign done_irq        = done_irq_r;
endmodule

// File: tb/tb_led_sense_seq.sv
// tb_led_sense_seq: scenario tasks with a scoreboard queue of expected bus
// read values, a pad model that discharges the pin a set number of cycles
// after the drive is released, and monitors for drive length and interrupts.
module tb_led_sense_seq;
    localparam int          NEVER  = 32'h7FFF_FFFF;
    localparam logic [31:0] A_STAT = 32'h0900_0000;
    localparam logic [31:0] A_CHG  = 32'h0900_0004;
    localparam logic [31:0] A_TMO  = 32'h0900_0008;
    localparam logic [31:0] A_RES  = 32'h0900_000C;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic pin_oe, pin_do, done_irq;
    logic pin_di = 1'b1;

    led_sense_seq_if bus_if();

    led_sense_seq dut (
        .clock    (clock),
        .resetn   (resetn),
        .bus      (bus_if),
        .pin_oe   (pin_oe),
        .pin_do   (pin_do),
        .pin_di   (pin_di),
        .done_irq (done_irq)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          dis_after = NEVER;
    int          lo_cnt = 0;
    int          oe_run = 0;
    int          last_oe_run = 0;
    int          irq_cnt = 0;
    int          irq_t[$];

    always @(posedge clock) cyc++;

    // Pad model: charged while driven, falls dis_after cycles after release.
    always @(negedge clock) begin
        if (pin_oe || dis_after == NEVER) begin
            pin_di = 1'b1;
            lo_cnt = 0;
        end else begin
            if (lo_cnt == dis_after) pin_di = 1'b0;
            lo_cnt++;
        end
    end

    // Monitors: length of the last drive pulse and interrupt timestamps.
    always @(negedge clock) begin
        if (pin_oe) oe_run++;
        else if (oe_run != 0) begin
            last_oe_run = oe_run;
            oe_run = 0;
        end
        if (done_irq) begin
            irq_cnt++;
            irq_t.push_back(cyc);
        end
    end

    task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat, output logic oe_ack);
        @(negedge clock);
        bus_if.iomem_valid = 1'b1;
        bus_if.iomem_addr  = addr;
        bus_if.iomem_wstrb = strb;
        bus_if.iomem_wdata = wdata;
        lat = -1; rdata = 32'd0; oe_ack = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clock); #1;
            if (bus_if.iomem_ready) begin
                lat = i; rdata = bus_if.iomem_rdata; oe_ack = pin_oe;
                break;
            end
        end
        @(negedge clock);
        bus_if.iomem_valid = 1'b0;
        bus_if.iomem_wstrb = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
        logic oe_ack;
        bus_xfer(addr, 4'b0000, 32'd0, rdata, lat, oe_ack);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata, output logic oe_ack);
        logic [31:0] rd;
        int lat;
        bus_xfer(addr, 4'b1111, wdata, rd, lat, oe_ack);
    endtask

    task automatic wait_irq(input int target, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (irq_cnt >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd, exp;
        int lat;
        logic oe;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (pin_oe !== 1'b0) begin n_bad++; $display("FAIL rst_oe: got %b want 0", pin_oe); end
        n_cmp++; if (pin_do !== 1'b0) begin n_bad++; $display("FAIL rst_do: got %b want 0", pin_do); end
        n_cmp++; if (bus_if.iomem_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", bus_if.iomem_ready); end
        n_cmp++; if (bus_if.iomem_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus_if.iomem_rdata); end
        n_cmp++; if (done_irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", done_irq); end
        resetn = 1'b1;
        exp_q.push_back(32'd0);
        bus_read(A_STAT, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL rst_stat: got %h want %h", rd, exp); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ready_latency: got %0d want 1", lat); end
        @(posedge clock); #1;
        n_cmp++; if (bus_if.iomem_ready !== 1'b0) begin n_bad++; $display("FAIL ready_one_cycle: got %b want 0", bus_if.iomem_ready); end
        exp_q.push_back(32'd1200);
        bus_read(A_CHG, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL rst_charge: got %h want %h", rd, exp); end
        exp_q.push_back(32'h00FF_FFFF);
        bus_read(A_TMO, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL rst_timeout: got %h want %h", rd, exp); end
        // Byte-lane write: only the low byte of CHARGE changes (0x4B0 -> 0x405).
        bus_xfer(A_CHG, 4'b0001, 32'hFFFF_FF05, rd, lat, oe);
        exp_q.push_back(32'h0000_0405);
        bus_read(A_CHG, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL wstrb_charge: got %h want %h", rd, exp); end
        bus_write(A_TMO, 32'hFFFF_FFFF, oe);
        exp_q.push_back(32'h00FF_FFFF);
        bus_read(A_TMO, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL upper_bits_zero: got %h want %h", rd, exp); end
        n_cmp++; if (pin_oe !== 1'b0) begin n_bad++; $display("FAIL idle_oe: got %b want 0", pin_oe); end
    endtask

    task automatic test_measure();
        logic [31:0] rd, exp;
        int lat, base;
        logic oe, ok;
        base = irq_cnt;
        bus_write(A_CHG, 32'd10, oe);
        bus_write(A_STAT, 32'd1, oe);
        dis_after = 50;
        repeat (3) @(negedge clock);
        bus_write(A_STAT, 32'd1, oe);   // start while busy must not restart the charge
        wait_irq(base + 1, 300, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL meas_irq_timeout: got %b want 1", ok); end
        repeat (5) @(negedge clock);
        n_cmp++; if (irq_cnt !== base + 1) begin n_bad++; $display("FAIL meas_irq_count: got %0d want %0d", irq_cnt, base + 1); end
        n_cmp++; if (last_oe_run !== 10) begin n_bad++; $display("FAIL meas_oe_len: got %0d want 10", last_oe_run); end
        exp_q.push_back(32'h0000_0002);
        exp_q.push_back(32'd52);
        exp_q.push_back(32'd52);
        exp_q.push_back(32'h0000_0000);
        bus_read(A_STAT, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL meas_stat_done: got %h want %h", rd, exp); end
        for (int k = 0; k < 2; k++) begin
            bus_read(A_RES, rd, lat);
            exp = exp_q.pop_front();
            n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL meas_result%0d: got %0d want %0d", k, rd, exp); end
        end
        bus_read(A_STAT, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL meas_stat_clr: got %h want %h", rd, exp); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd, exp;
        int lat, base;
        logic oe, ok;
        dis_after = NEVER;
        base = irq_cnt;
        bus_write(A_TMO, 32'd100, oe);
        bus_write(A_CHG, 32'd0, oe);   // zero charge behaves as one cycle
        exp_q.push_back(32'd0);
        bus_read(A_CHG, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL tmo_charge_zero: got %h want %h", rd, exp); end
        bus_write(A_STAT, 32'd1, oe);
        wait_irq(base + 1, 400, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tmo_irq_timeout: got %b want 1", ok); end
        n_cmp++; if (last_oe_run !== 1) begin n_bad++; $display("FAIL tmo_oe_len: got %0d want 1", last_oe_run); end
        exp_q.push_back(32'h0000_0006);
        exp_q.push_back(32'd100);
        exp_q.push_back(32'h0000_0000);
        bus_read(A_STAT, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL tmo_stat: got %h want %h", rd, exp); end
        bus_read(A_RES, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL tmo_result: got %0d want %0d", rd, exp); end
        bus_read(A_STAT, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL tmo_stat_clr: got %h want %h", rd, exp); end
    endtask

    task automatic test_abort();
        logic [31:0] rd, exp;
        int lat, base;
        logic oe;
        base = irq_cnt;
        bus_write(A_CHG, 32'd20, oe);
        bus_write(A_STAT, 32'd1, oe);
        exp_q.push_back(32'h0000_0011);
        bus_read(A_STAT, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL abort_busy: got %h want %h", rd, exp); end
        bus_write(A_STAT, 32'd5, oe);  // start|abort: abort wins
        n_cmp++; if (oe !== 1'b0) begin n_bad++; $display("FAIL abort_oe: got %b want 0", oe); end
        repeat (30) @(negedge clock);
        n_cmp++; if (pin_oe !== 1'b0) begin n_bad++; $display("FAIL abort_oe_stays: got %b want 0", pin_oe); end
        n_cmp++; if (irq_cnt !== base) begin n_bad++; $display("FAIL abort_no_irq: got %0d want %0d", irq_cnt, base); end
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'd100);
        bus_read(A_STAT, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL abort_idle: got %h want %h", rd, exp); end
        bus_read(A_RES, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL abort_result_kept: got %0d want %0d", rd, exp); end
    endtask

    task automatic test_cont();
        logic [31:0] rd, exp;
        int lat, base;
        logic oe, ok;
        base = irq_cnt;
        bus_write(A_CHG, 32'd4, oe);
        dis_after = 4;
        bus_write(A_STAT, 32'd3, oe);  // start|cont
        wait_irq(base + 3, 200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL cont_irq_timeout: got %b want 1", ok); end
        for (int k = 1; k < 3; k++) begin
            n_cmp++;
            if (irq_t.size() < base + 3 || irq_t[base + k] - irq_t[base + k - 1] !== 12) begin
                n_bad++; $display("FAIL cont_period%0d: got %0d want 12", k,
                                  (irq_t.size() < base + 3) ? -1 : irq_t[base + k] - irq_t[base + k - 1]);
            end
        end
        bus_write(A_STAT, 32'd0, oe);  // clear cont: current measurement still completes
        repeat (60) @(negedge clock);
        n_cmp++; if (irq_cnt !== base + 4) begin n_bad++; $display("FAIL cont_stop: got %0d want %0d", irq_cnt, base + 4); end
        exp_q.push_back(32'h0000_0002);
        exp_q.push_back(32'd6);
        bus_read(A_STAT, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL cont_stat: got %h want %h", rd, exp); end
        bus_read(A_RES, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL cont_result: got %0d want %0d", rd, exp); end
    endtask

    task automatic test_decode_reset();
        logic [31:0] rd, exp;
        int lat;
        logic oe;
        bus_read(32'h0800_0000, rd, lat);
        n_cmp++; if (lat !== -1) begin n_bad++; $display("FAIL decode_other: got lat %0d want none", lat); end
        dis_after = NEVER;
        // Reset in the middle of CHARGE releases the pad on that edge.
        bus_write(A_CHG, 32'd200, oe);
        bus_write(A_STAT, 32'd1, oe);
        repeat (5) @(negedge clock);
        n_cmp++; if (pin_do !== 1'b1) begin n_bad++; $display("FAIL charge_do: got %b want 1", pin_do); end
        resetn = 1'b0;
        @(posedge clock); #1;
        n_cmp++; if (pin_oe !== 1'b0) begin n_bad++; $display("FAIL rst_chg_oe: got %b want 0", pin_oe); end
        n_cmp++; if (pin_do !== 1'b0) begin n_bad++; $display("FAIL rst_chg_do: got %b want 0", pin_do); end
        @(negedge clock);
        resetn = 1'b1;
        exp_q.push_back(32'd1200);
        bus_read(A_CHG, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL rst_charge_again: got %h want %h", rd, exp); end
        // Reset in MEASURE with a bus request pending.
        bus_write(A_CHG, 32'd4, oe);
        bus_write(A_TMO, 32'd1000, oe);
        bus_write(A_STAT, 32'd1, oe);
        repeat (6) @(negedge clock);
        exp_q.push_back(32'h0000_0021);
        bus_read(A_STAT, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL in_measure: got %h want %h", rd, exp); end
        @(negedge clock);
        bus_if.iomem_valid = 1'b1; bus_if.iomem_addr = A_STAT; bus_if.iomem_wstrb = 4'b0000;
        resetn = 1'b0;
        @(posedge clock); #1;
        n_cmp++; if (pin_oe !== 1'b0) begin n_bad++; $display("FAIL rst_meas_oe: got %b want 0", pin_oe); end
        n_cmp++; if (bus_if.iomem_ready !== 1'b0) begin n_bad++; $display("FAIL rst_meas_ready: got %b want 0", bus_if.iomem_ready); end
        n_cmp++; if (bus_if.iomem_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_meas_rdata: got %h want 0", bus_if.iomem_rdata); end
        n_cmp++; if (done_irq !== 1'b0) begin n_bad++; $display("FAIL rst_meas_irq: got %b want 0", done_irq); end
        @(negedge clock);
        bus_if.iomem_valid = 1'b0;
        resetn = 1'b1;
        exp_q.push_back(32'h0000_0000);
        bus_read(A_STAT, rd, lat);
        exp = exp_q.pop_front();
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL rst_meas_stat: got %h want %h", rd, exp); end
    endtask

    initial begin
        bus_if.iomem_valid = 1'b0;
        bus_if.iomem_wstrb = 4'b0000;
        bus_if.iomem_addr  = 32'd0;
        bus_if.iomem_wdata = 32'd0;
        test_reset();
        test_measure();
        test_timeout();
        test_abort();
        test_cont();
        test_decode_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end by itself");
        $fatal(1);
    end
endmodule
